// File: rtl/traffic_pkg.sv
// Shared light and fault encodings for the intersection road-side model.
//   light_t        : one-hot street light code driven by the controller
//   fault_t        : safety-fault code captured by the checker
//   is_legal_light : true when a 3-bit light code is one of the one-hot values
package traffic_pkg;

    typedef enum logic [2:0] {
        GREEN  = 3'b001,
        YELLOW = 3'b010,
        RED    = 3'b100
    } light_t;

    typedef enum logic [1:0] {
        FAULT_NONE     = 2'b00,
        FAULT_ILLEGAL  = 2'b01,
        FAULT_CONFLICT = 2'b10,
        FAULT_SKIP     = 2'b11
    } fault_t;

    function automatic logic is_legal_light(input logic [2:0] l);
        return (l == GREEN) || (l == YELLOW) || (l == RED);
    endfunction

endpackage

// File: rtl/street_queue.sv
// Car queue for one street: counts arrivals, releases one car every
// DEPART_CYCLES green cycles, saturates at 2**QW-1 with a sticky overflow.
//   clk, reset : clock, synchronous active-high reset
//   light      : street light code (only GREEN drains the queue)
//   arrive     : one car arrives this cycle
//   q          : registered queue occupancy
//   t          : traffic sensor, queue non-empty (combinational from q)
//   ovf        : sticky, an arrival was dropped on a full queue
module street_queue
    import traffic_pkg::*;
#(
    parameter int unsigned QW            = 4,
    parameter int unsigned DEPART_CYCLES = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [2:0]    light,
    input  logic          arrive,
    output logic [QW-1:0] q,
    output logic          t,
    output logic          ovf
);

    localparam int unsigned   TW     = (DEPART_CYCLES > 1) ? $clog2(DEPART_CYCLES) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(DEPART_CYCLES - 1);
    localparam logic [QW-1:0] Q_MAX  = '1;

    logic [TW-1:0] timer_q, timer_d;
    logic [QW-1:0] q_q, q_d;
    logic          ovf_q, ovf_d;
    logic          green;
    logic          depart;

    // Departure timer and occupancy next-state
    always_comb begin
        timer_d = '0;
        q_d     = q_q;
        ovf_d   = ovf_q;
        green   = (light == GREEN);
        depart  = green && (timer_q == T_LAST) && (q_q != '0);

        // Timer wraps on its last count whether or not a car left
        if (green && (timer_q != T_LAST)) begin
            timer_d = timer_q + TW'(1);
        end

        if (arrive && !depart) begin
            if (q_q == Q_MAX) begin
                ovf_d = 1'b1;
            end else begin
                q_d = q_q + QW'(1);
            end
        end else if (depart && !arrive) begin
            q_d = q_q - QW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            timer_q <= '0;
            q_q     <= '0;
            ovf_q   <= 1'b0;
        end else begin
            timer_q <= timer_d;
            q_q     <= q_d;
            ovf_q   <= ovf_d;
        end
    end

    assign q   = q_q;
    assign t   = (q_q != '0);
    assign ovf = ovf_q;

endmodule

// File: rtl/intersection_model.sv
// Road side of the traffic-light interface: two street queues driving the
// traffic sensors, plus a safety checker on the light codes with a sticky
// first-fault capture.
//   clk, reset         : clock, synchronous active-high reset
//   la, lb             : light codes for streets A and B
//   arrive_a, arrive_b : car arrival strobes
//   ta, tb             : traffic sensors (queue non-empty)
//   qa, qb             : queue occupancies
//   ovf_a, ovf_b       : sticky queue-overflow flags
//   fault, fault_code  : sticky safety fault and code of the first one seen
module intersection_model
    import traffic_pkg::*;
#(
    parameter int unsigned QW            = 4,
    parameter int unsigned DEPART_CYCLES = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [2:0]    la,
    input  logic [2:0]    lb,
    input  logic          arrive_a,
    input  logic          arrive_b,
    output logic          ta,
    output logic          tb,
    output logic [QW-1:0] qa,
    output logic [QW-1:0] qb,
    output logic          ovf_a,
    output logic          ovf_b,
    output logic          fault,
    output logic [1:0]    fault_code
);

    street_queue #(.QW(QW), .DEPART_CYCLES(DEPART_CYCLES)) u_queue_a (
        .clk    (clk),
        .reset  (reset),
        .light  (la),
        .arrive (arrive_a),
        .q      (qa),
        .t      (ta),
        .ovf    (ovf_a)
    );

    street_queue #(.QW(QW), .DEPART_CYCLES(DEPART_CYCLES)) u_queue_b (
        .clk    (clk),
        .reset  (reset),
        .light  (lb),
        .arrive (arrive_b),
        .q      (qb),
        .t      (tb),
        .ovf    (ovf_b)
    );

    logic [2:0] prev_la_q, prev_lb_q;
    logic       fault_q, fault_d;
    fault_t     code_q, code_d;
    fault_t     cur_fault;

    // Classify this cycle's lights, then latch only the first fault
    always_comb begin
        cur_fault = FAULT_NONE;
        fault_d   = fault_q;
        code_d    = code_q;

        if (!is_legal_light(la) || !is_legal_light(lb)) begin
            cur_fault = FAULT_ILLEGAL;
        end else if ((la != RED) && (lb != RED)) begin
            cur_fault = FAULT_CONFLICT;
        end else if (((prev_la_q == GREEN) && (la == RED)) ||
                     ((prev_lb_q == GREEN) && (lb == RED))) begin
            cur_fault = FAULT_SKIP;
        end

        if (!fault_q && (cur_fault != FAULT_NONE)) begin
            fault_d = 1'b1;
            code_d  = cur_fault;
        end
    end

    // Previous lights track raw inputs, illegal codes included
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_la_q <= RED;
            prev_lb_q <= RED;
            fault_q   <= 1'b0;
            code_q    <= FAULT_NONE;
        end else begin
            prev_la_q <= la;
            prev_lb_q <= lb;
            fault_q   <= fault_d;
            code_q    <= code_d;
        end
    end

    assign fault      = fault_q;
    assign fault_code = code_q;

endmodule
